// File: rtl/pdp8_brk.sv
// Memory data-break arbiter: shares one RAM port between the CPU and device break requests.
// Optional three-cycle-break increment (read, write data+1) is enabled with `define BRK_INCR_EN.
`default_nettype none

module pdp8_brk #(
    parameter int TIMEOUT = 255,
    parameter int BRK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_ram_read_req,
    input  logic        io_ram_write_req,
    input  logic [14:0] io_ram_ma,
    input  logic [11:0] io_ram_out,
    output logic [11:0] io_ram_in,
    output logic        io_ram_done,
    input  logic        cpu_ram_read_req,
    input  logic        cpu_ram_write_req,
    input  logic [14:0] cpu_ram_ma,
    input  logic [11:0] cpu_ram_wdata,
    output logic [11:0] cpu_ram_rdata,
    output logic        cpu_ram_done,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_wdata,
    input  logic [11:0] ram_rdata,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic        ram_done,
    output logic        brk_active,
    output logic        brk_timeout
);

    localparam int GW = (BRK_MAX < 1) ? 1 : $clog2(BRK_MAX + 1);
    localparam logic [GW-1:0] BRK_LIM = GW'(BRK_MAX);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

`ifdef BRK_INCR_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_RD  = 3'd1,
        ACC_WR  = 3'd2,
        RESP    = 3'd3,
        ACC_INC = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_RD = 2'd1,
        ACC_WR = 2'd2,
        RESP   = 2'd3
    } state_t;
`endif

    state_t          state_reg;
    state_t          state_next;
    logic            owner_cpu_reg;
    logic [GW-1:0]   grant_cnt_reg;
    logic [7:0]      wait_cnt_reg;
    logic [14:0]     addr_reg;
    logic [11:0]     wdata_reg;
    logic [11:0]     io_data_reg;
    logic [11:0]     cpu_data_reg;
    logic            timeout_reg;
`ifdef BRK_INCR_EN
    logic            incr_reg;
    logic            dev_incr;
`endif

    logic dev_req;
    logic cpu_req;
    logic grant_cpu;
    logic grant_dev;
    logic in_access;
    logic wait_expired;

    assign dev_req      = io_ram_read_req | io_ram_write_req;
    assign cpu_req      = cpu_ram_read_req | cpu_ram_write_req;
    // The CPU only wins against a pending device once the device has used up its burst.
    assign grant_cpu    = cpu_req && (!dev_req || (grant_cnt_reg == BRK_LIM));
    assign grant_dev    = dev_req && !grant_cpu;
    assign wait_expired = (wait_cnt_reg == WAIT_LAST);
`ifdef BRK_INCR_EN
    assign dev_incr     = io_ram_read_req & io_ram_write_req;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_cpu) begin
                    state_next = cpu_ram_write_req ? ACC_WR : ACC_RD;
                end else if (grant_dev) begin
`ifdef BRK_INCR_EN
                    state_next = (io_ram_write_req && !io_ram_read_req) ? ACC_WR : ACC_RD;
`else
                    state_next = io_ram_write_req ? ACC_WR : ACC_RD;
`endif
                end
            end
`ifdef BRK_INCR_EN
            ACC_RD: begin
                if (ram_done) begin
                    state_next = incr_reg ? ACC_INC : RESP;
                end else if (wait_expired) begin
                    state_next = RESP;
                end
            end
            ACC_INC: begin
                if (ram_done || wait_expired) begin
                    state_next = RESP;
                end
            end
`else
            ACC_RD: begin
                if (ram_done || wait_expired) begin
                    state_next = RESP;
                end
            end
`endif
            ACC_WR: begin
                if (ram_done || wait_expired) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ram_rd    = (state_reg == ACC_RD);
`ifdef BRK_INCR_EN
    assign ram_wr    = (state_reg == ACC_WR) || (state_reg == ACC_INC);
`else
    assign ram_wr    = (state_reg == ACC_WR);
`endif
    assign in_access = ram_rd | ram_wr;

    assign io_ram_done   = (state_reg == RESP) && !owner_cpu_reg;
    assign cpu_ram_done  = (state_reg == RESP) && owner_cpu_reg;
    assign brk_active    = (state_reg != IDLE) && !owner_cpu_reg;
    assign io_ram_in     = io_data_reg;
    assign cpu_ram_rdata = cpu_data_reg;
    assign ram_addr      = addr_reg;
    assign ram_wdata     = wdata_reg;
    assign brk_timeout   = timeout_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            owner_cpu_reg <= 1'b0;
            grant_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            io_data_reg   <= '0;
            cpu_data_reg  <= '0;
            timeout_reg   <= 1'b0;
`ifdef BRK_INCR_EN
            incr_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                wait_cnt_reg <= '0;
                if (grant_cpu) begin
                    owner_cpu_reg <= 1'b1;
                    addr_reg      <= cpu_ram_ma;
                    wdata_reg     <= cpu_ram_wdata;
                    grant_cnt_reg <= '0;
`ifdef BRK_INCR_EN
                    incr_reg      <= 1'b0;
`endif
                end else if (grant_dev) begin
                    owner_cpu_reg <= 1'b0;
                    addr_reg      <= io_ram_ma;
                    wdata_reg     <= io_ram_out;
`ifdef BRK_INCR_EN
                    incr_reg      <= dev_incr;
`endif
                    if (!cpu_req) begin
                        grant_cnt_reg <= '0;
                    end else if (grant_cnt_reg != BRK_LIM) begin
                        grant_cnt_reg <= grant_cnt_reg + GW'(1);
                    end
                end else begin
                    grant_cnt_reg <= '0;
                end
            end else if (in_access) begin
                if (ram_done) begin
                    wait_cnt_reg <= '0;
                    if (state_reg == ACC_RD) begin
`ifdef BRK_INCR_EN
                        // Read phase of an increment break: stage data+1 for the write phase.
                        if (incr_reg) begin
                            wdata_reg <= ram_rdata + 12'd1;
                        end else if (owner_cpu_reg) begin
                            cpu_data_reg <= ram_rdata;
                        end else begin
                            io_data_reg <= ram_rdata;
                        end
`else
                        if (owner_cpu_reg) begin
                            cpu_data_reg <= ram_rdata;
                        end else begin
                            io_data_reg <= ram_rdata;
                        end
`endif
                    end
`ifdef BRK_INCR_EN
                    else if (state_reg == ACC_INC) begin
                        io_data_reg <= wdata_reg;
                    end
`endif
                end else if (wait_expired) begin
                    timeout_reg <= 1'b1;
                    if (owner_cpu_reg) begin
                        cpu_data_reg <= '0;
                    end else begin
                        io_data_reg <= '0;
                    end
                end else begin
                    wait_cnt_reg <= wait_cnt_reg + 8'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pdp8_brk.sv
// Scoreboard bench for pdp8_brk: a RAM model checks each strobe phase, a monitor checks each done pulse.
// Follows `define BRK_INCR_EN for the increment-break vectors.
`timescale 1ns/1ps

module tb_pdp8_brk;

    localparam int TIMEOUT = 255;
    localparam int BRK_MAX = 4;

    logic        clk;
    logic        reset;
    logic        io_ram_read_req, io_ram_write_req;
    logic [14:0] io_ram_ma;
    logic [11:0] io_ram_out;
    logic [11:0] io_ram_in;
    logic        io_ram_done;
    logic        cpu_ram_read_req, cpu_ram_write_req;
    logic [14:0] cpu_ram_ma;
    logic [11:0] cpu_ram_wdata;
    logic [11:0] cpu_ram_rdata;
    logic        cpu_ram_done;
    logic [14:0] ram_addr;
    logic [11:0] ram_wdata;
    logic [11:0] ram_rdata;
    logic        ram_rd, ram_wr, ram_done;
    logic        brk_active, brk_timeout;

    pdp8_brk #(.TIMEOUT(TIMEOUT), .BRK_MAX(BRK_MAX)) dut (
        .clk(clk), .reset(reset),
        .io_ram_read_req(io_ram_read_req), .io_ram_write_req(io_ram_write_req),
        .io_ram_ma(io_ram_ma), .io_ram_out(io_ram_out),
        .io_ram_in(io_ram_in), .io_ram_done(io_ram_done),
        .cpu_ram_read_req(cpu_ram_read_req), .cpu_ram_write_req(cpu_ram_write_req),
        .cpu_ram_ma(cpu_ram_ma), .cpu_ram_wdata(cpu_ram_wdata),
        .cpu_ram_rdata(cpu_ram_rdata), .cpu_ram_done(cpu_ram_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_done(ram_done),
        .brk_active(brk_active), .brk_timeout(brk_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [14:0] addr;
        logic [11:0] wdata;
        bit          active;
        int          cycles;
    } acc_t;

    typedef struct {
        bit          dev;
        logic [11:0] data;
        bit          tmo;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];

    int checks;
    int errors;
    int lat;
    logic [11:0] mem [0:32767];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0o required=%0o", name, act, req);
        end
    endtask

    task automatic exp_acc(input bit wr, input logic [14:0] a, input logic [11:0] wd,
                           input bit act, input int cyc);
        acc_t e;
        e.wr = wr; e.addr = a; e.wdata = wd; e.active = act; e.cycles = cyc;
        acc_q.push_back(e);
    endtask

    task automatic exp_done(input bit dev, input logic [11:0] d, input bit tmo);
        done_t e;
        e.dev = dev; e.data = d; e.tmo = tmo;
        done_q.push_back(e);
    endtask

    // RAM model: answers each strobe phase after lat cycles (lat 0 = never) and checks it.
    initial begin
        logic [1:0] cur, prev;
        int cnt;
        acc_t ca;
        ram_done = 1'b0;
        ram_rdata = '0;
        prev = 2'b00;
        cnt = 0;
        ca.wr = 0; ca.addr = '0; ca.wdata = '0; ca.active = 0; ca.cycles = 0;
        forever begin
            @(negedge clk);
            cur = {ram_rd, ram_wr};
            ram_done = 1'b0;
            if (cur != prev && prev != 2'b00) begin
                chk("strobe_cycles", cnt, ca.cycles);
                cnt = 0;
            end
            if (cur != 2'b00 && cur != prev) begin
                cnt = 0;
                if (acc_q.size() == 0) begin
                    chk("unexpected_access", 1, 0);
                end else begin
                    ca = acc_q.pop_front();
                    chk("acc_wr", ram_wr, ca.wr);
                    chk("acc_addr", ram_addr, ca.addr);
                    chk("acc_active", brk_active, ca.active);
                    if (ca.wr) chk("acc_wdata", ram_wdata, ca.wdata);
                    $display("ram %s addr=%05o wdata=%04o active=%0b", ram_wr ? "wr" : "rd",
                             ram_addr, ram_wdata, brk_active);
                end
            end
            if (cur != 2'b00) begin
                cnt++;
                if (lat != 0 && cnt == lat) begin
                    ram_done = 1'b1;
                    if (ram_wr) mem[ram_addr] = ram_wdata;
                    else ram_rdata = mem[ram_addr];
                end
            end
            prev = cur;
        end
    end

    // Done monitor: every done pulse must match the next scoreboard entry.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (cpu_ram_done === 1'b1 || io_ram_done === 1'b1) begin
                chk("done_exclusive", cpu_ram_done & io_ram_done, 0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_owner", io_ram_done, e.dev);
                    chk("done_data", e.dev ? io_ram_in : cpu_ram_rdata, e.data);
                    chk("done_timeout", brk_timeout, e.tmo);
                    $display("done %s data=%04o timeout=%0b", io_ram_done ? "dev" : "cpu",
                             io_ram_done ? io_ram_in : cpu_ram_rdata, brk_timeout);
                end
            end
        end
    end

    task automatic cpu_access(input bit wr, input logic [14:0] a, input logic [11:0] d);
        int n;
        @(negedge clk);
        cpu_ram_read_req = !wr; cpu_ram_write_req = wr; cpu_ram_ma = a; cpu_ram_wdata = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ram_done && n < 1000);
        chk("cpu_done_seen", cpu_ram_done, 1);
        cpu_ram_read_req = 1'b0; cpu_ram_write_req = 1'b0;
    endtask

    task automatic dev_access(input bit rd, input bit wr, input logic [14:0] a, input logic [11:0] d);
        int n;
        @(negedge clk);
        io_ram_read_req = rd; io_ram_write_req = wr; io_ram_ma = a; io_ram_out = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!io_ram_done && n < 1000);
        chk("dev_done_seen", io_ram_done, 1);
        io_ram_read_req = 1'b0; io_ram_write_req = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dones;
        checks = 0; errors = 0; lat = 2;
        reset = 1'b0;
        io_ram_read_req = 0; io_ram_write_req = 0; io_ram_ma = '0; io_ram_out = '0;
        cpu_ram_read_req = 0; cpu_ram_write_req = 0; cpu_ram_ma = '0; cpu_ram_wdata = '0;
        mem[15'o00200] = 12'o1234;
        mem[15'o00100] = 12'o4321;
        mem[15'o00050] = 12'o7777;
        mem[15'o00051] = 12'o0123;

        repeat (3) @(negedge clk);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_wr", ram_wr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_rdata", cpu_ram_rdata, 0);
        chk("rst_timeout", brk_timeout, 0);
        chk("rst_active", brk_active, 0);
        reset = 1'b1;

        // CPU read, RAM answers on the second strobe cycle
        lat = 2;
        exp_acc(0, 15'o00200, 12'o0000, 0, 2);
        exp_done(0, 12'o1234, 0);
        cpu_access(0, 15'o00200, 12'o0000);

        // Device write and CPU read raised together: device first
        exp_acc(1, 15'o17777, 12'o5252, 1, 2);
        exp_acc(0, 15'o00200, 12'o0000, 0, 2);
        exp_done(1, 12'o0000, 0);
        exp_done(0, 12'o1234, 0);
        fork
            cpu_access(0, 15'o00200, 12'o0000);
            dev_access(0, 1, 15'o17777, 12'o5252);
        join
        chk("mem_17777", mem[15'o17777], 12'o5252);

        // Burst limit: D,D,D,D,C,D,D,D,D,C
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                exp_acc(0, 15'o00200, 12'o0000, 0, 1);
                exp_done(0, 12'o1234, 0);
            end else begin
                exp_acc(0, 15'o00100, 12'o0000, 1, 1);
                exp_done(1, 12'o4321, 0);
            end
        end
        @(negedge clk);
        io_ram_read_req = 1; io_ram_ma = 15'o00100;
        cpu_ram_read_req = 1; cpu_ram_ma = 15'o00200;
        dones = 0; n = 0;
        while (dones < 10 && n < 400) begin
            @(negedge clk);
            n++;
            if (cpu_ram_done || io_ram_done) dones++;
        end
        chk("order_done_count", dones, 10);
        io_ram_read_req = 0; cpu_ram_read_req = 0;

        // RAM never answers: forced completion after TIMEOUT cycles
        lat = 0;
        exp_acc(0, 15'o00300, 12'o0000, 0, TIMEOUT);
        exp_done(0, 12'o0000, 1);
        cpu_access(0, 15'o00300, 12'o0000);
        repeat (5) @(negedge clk);
        chk("timeout_sticky", brk_timeout, 1);

        // Reset in the middle of a device write
        exp_acc(1, 15'o00400, 12'o3333, 1, 3);
        @(negedge clk);
        io_ram_write_req = 1; io_ram_ma = 15'o00400; io_ram_out = 12'o3333;
        n = 0;
        while (!ram_wr && n < 20) begin @(negedge clk); n++; end
        chk("rst_wr_seen", ram_wr, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        io_ram_write_req = 0;
        @(negedge clk);
        chk("midrst_ram_wr", ram_wr, 0);
        chk("midrst_timeout", brk_timeout, 0);
        chk("midrst_io_in", io_ram_in, 0);
        chk("midrst_addr", ram_addr, 0);
        chk("midrst_active", brk_active, 0);
        reset = 1'b1;

        // Device read+write together
        lat = 2;
`ifdef BRK_INCR_EN
        exp_acc(0, 15'o00050, 12'o0000, 1, 2);
        exp_acc(1, 15'o00050, 12'o0000, 1, 2);
        exp_done(1, 12'o0000, 0);
        dev_access(1, 1, 15'o00050, 12'o1111);
        chk("incr_mem_wrap", mem[15'o00050], 12'o0000);
        exp_acc(0, 15'o00051, 12'o0000, 1, 2);
        exp_acc(1, 15'o00051, 12'o0124, 1, 2);
        exp_done(1, 12'o0124, 0);
        dev_access(1, 1, 15'o00051, 12'o2222);
        chk("incr_mem", mem[15'o00051], 12'o0124);
`else
        exp_acc(1, 15'o00050, 12'o1111, 1, 2);
        exp_done(1, 12'o0000, 0);
        dev_access(1, 1, 15'o00050, 12'o1111);
        chk("both_mem_write", mem[15'o00050], 12'o1111);
        exp_acc(1, 15'o00051, 12'o2222, 1, 2);
        exp_done(1, 12'o0000, 0);
        dev_access(1, 1, 15'o00051, 12'o2222);
        chk("both_mem_write2", mem[15'o00051], 12'o2222);
`endif

        repeat (5) @(negedge clk);
        chk("acc_queue_empty", acc_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
